// File: rtl/bomberman_pkg.sv
// Shared constants, FSM state type and tile indexing for the bomberman box map.
package bomberman_pkg;

  localparam int MAP_COLS = 15;
  localparam int MAP_ROWS = 11;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CLEAR,
    QUERY,
    DONE
  } state_t;

  // Bit positions inside the blocked vector.
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  function automatic int tile_idx(int col, int row, int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/box_map_ram.sv
// One-bit-per-tile box map: combinational read / synchronous write port plus a
// registered render read port that returns pre-write data on a same-cycle write.
module box_map_ram
  import bomberman_pkg::*;
#(
  parameter int DEPTH = MAP_COLS * MAP_ROWS,
  parameter int AW    = $clog2(MAP_COLS * MAP_ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          rdata,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_ok,
  output logic          rd_box
);

  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_box <= 1'b0;
    else       rd_box <= rd_ok & mem[rd_addr];
  end

endmodule

// File: rtl/box_map_ctrl.sv
// Arena box map controller: fills the map after reset, clears boxes around
// explosions and answers four-way collision queries with fixed latency.
module box_map_ctrl
  import bomberman_pkg::*;
#(
  parameter int COLS = MAP_COLS,
  parameter int ROWS = MAP_ROWS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       exp_req,
  input  logic [3:0] exp_col,
  input  logic [3:0] exp_row,
  output logic       exp_ack,
  output logic [2:0] destroyed,
  input  logic       qry_req,
  input  logic [3:0] qry_col,
  input  logic [3:0] qry_row,
  output logic       qry_ack,
  output logic [3:0] blocked,
  input  logic [3:0] rd_col,
  input  logic [3:0] rd_row,
  output logic       rd_box,
  output logic       busy,
  output logic [7:0] box_count
);

  localparam int TILES = COLS * ROWS;
  localparam int AW    = $clog2(TILES);
  localparam logic signed [4:0] COLS_S = 5'(COLS);
  localparam logic signed [4:0] ROWS_S = 5'(ROWS);

  state_t state_q, state_d;

  logic [AW-1:0] init_idx;
  logic [3:0]    init_col, init_row;
  logic          init_box;
  logic [2:0]    step;
  logic [3:0]    lat_col, lat_row;
  logic          op_exp, centre_ok;

  logic [2:0]        sel;
  logic signed [4:0] dc, dr, tc, tr;
  logic              in_grid, pillar, box_rd;
  logic [AW-1:0]     t_idx, ram_addr, rd_idx;
  logic [1:0]        qbit;
  logic              we, wdata, rd_ok;

  assign init_box = ~init_col[0] & ~init_row[0] &
                    (({1'b0, init_col} + {1'b0, init_row}) >= 5'd3);

  // Current target tile: sel 0 = centre, 1..4 = up, down, left, right.
  always_comb begin
    sel = (state_q == QUERY) ? (step + 3'd1) : step;
    dc  = 5'sd0;
    dr  = 5'sd0;
    case (sel)
      3'd1:    dr = -5'sd1;
      3'd2:    dr = 5'sd1;
      3'd3:    dc = -5'sd1;
      3'd4:    dc = 5'sd1;
      default: ;
    endcase
    tc      = $signed({1'b0, lat_col}) + dc;
    tr      = $signed({1'b0, lat_row}) + dr;
    in_grid = centre_ok && (tc >= 5'sd0) && (tc < COLS_S) && (tr >= 5'sd0) && (tr < ROWS_S);
    pillar  = tc[0] & tr[0];
    t_idx   = in_grid ? AW'(tile_idx(int'(tc), int'(tr), COLS)) : '0;
    case (step)
      3'd0:    qbit = 2'(DIR_UP);
      3'd1:    qbit = 2'(DIR_DOWN);
      3'd2:    qbit = 2'(DIR_LEFT);
      default: qbit = 2'(DIR_RIGHT);
    endcase
  end

  assign rd_ok  = ({1'b0, rd_col} < 5'(COLS)) && ({1'b0, rd_row} < 5'(ROWS)) &&
                  !(rd_col[0] & rd_row[0]);
  assign rd_idx = rd_ok ? AW'(tile_idx(int'(rd_col), int'(rd_row), COLS)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    we       = 1'b0;
    wdata    = 1'b0;
    ram_addr = t_idx;
    case (state_q)
      INIT: begin
        we       = 1'b1;
        wdata    = init_box;
        ram_addr = init_idx;
        if (init_idx == AW'(TILES - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (exp_req)      state_d = CLEAR;
        else if (qry_req) state_d = QUERY;
      end
      CLEAR: begin
        we = in_grid & box_rd;
        if (step == 3'd4) state_d = DONE;
      end
      QUERY: begin
        if (step == 3'd3) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_idx  <= '0;
      init_col  <= '0;
      init_row  <= '0;
      step      <= '0;
      lat_col   <= '0;
      lat_row   <= '0;
      op_exp    <= 1'b0;
      centre_ok <= 1'b0;
      destroyed <= '0;
      blocked   <= '0;
      box_count <= '0;
    end else begin
      case (state_q)
        INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_col == 4'(COLS - 1)) begin
            init_col <= '0;
            init_row <= init_row + 4'd1;
          end else begin
            init_col <= init_col + 4'd1;
          end
          if (init_box) box_count <= box_count + 8'd1;
        end
        IDLE: begin
          step <= '0;
          if (exp_req) begin
            op_exp    <= 1'b1;
            lat_col   <= exp_col;
            lat_row   <= exp_row;
            centre_ok <= ({1'b0, exp_col} < 5'(COLS)) && ({1'b0, exp_row} < 5'(ROWS));
            destroyed <= '0;
          end else if (qry_req) begin
            op_exp    <= 1'b0;
            lat_col   <= qry_col;
            lat_row   <= qry_row;
            centre_ok <= ({1'b0, qry_col} < 5'(COLS)) && ({1'b0, qry_row} < 5'(ROWS));
            blocked   <= '0;
          end
        end
        CLEAR: begin
          step <= step + 3'd1;
          if (in_grid && box_rd) begin
            destroyed <= destroyed + 3'd1;
            box_count <= box_count - 8'd1;
          end
        end
        QUERY: begin
          step <= step + 3'd1;
          if (!in_grid || pillar || box_rd) blocked[qbit] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign exp_ack = (state_q == DONE) && op_exp;
  assign qry_ack = (state_q == DONE) && !op_exp;
  assign busy    = (state_q != IDLE);

  box_map_ram #(
    .DEPTH(TILES),
    .AW   (AW)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .addr   (ram_addr),
    .wdata  (wdata),
    .rdata  (box_rd),
    .rd_addr(rd_idx),
    .rd_ok  (rd_ok),
    .rd_box (rd_box)
  );

endmodule
